mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 36 +++
 rtl/mem_access_unit_lane_align.sv | 57 +++++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit.
//   - RV32 load/store opcodes and funct3 encodings
//   - FSM state encoding for mem_access_unit
//   - helpers that classify a funct3/address pair
package mem_access_unit_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } memState_t;

  // Encodings that no RV32 load or store uses.
  function automatic logic isIllegalF3(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // funct3[1:0] carries the access size: 00 byte, 01 half, 10 word.
  function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] addrLo);
    return ((f3[1:0] == 2'b01) && addrLo[0]) ||
           ((f3[1:0] == 2'b10) && (addrLo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: purely combinational lane steering for one access.
//   funct3   in  3   access type
//   addrLo   in  2   byte offset within the word
//   wdata    in  32  store data as given by the core
//   rdata    in  32  word returned by data memory
//   be       out 4   byte enables for stores
//   wdataRep out 32  store data replicated onto every lane
//   rdataExt out 32  selected and sign/zero-extended load result
// Misaligned offsets are truncated: halfwords use addrLo[1], words ignore addrLo.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdataRep,
  output logic [31:0] rdataExt
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    be       = 4'b1111;
    wdataRep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be       = 4'b0001 << addrLo;
        wdataRep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be       = 4'b0011 << {addrLo[1], 1'b0};
        wdataRep = {2{wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wdataRep = wdata;
      end
    endcase
  end

  always_comb begin
    byteSel  = rdata[{addrLo, 3'b000} +: 8];
    halfSel  = addrLo[1] ? rdata[31:16] : rdata[15:0];
    rdataExt = rdata;
    case (funct3)
      F3_LB:   rdataExt = {{24{byteSel[7]}}, byteSel};
      F3_LBU:  rdataExt = {24'h000000, byteSel};
      F3_LH:   rdataExt = {{16{halfSel[15]}}, halfSel};
      F3_LHU:  rdataExt = {16'h0000, halfSel};
      default: rdataExt = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer toward a handshaked data memory.
//   clk, rst             single clock, synchronous active-high reset
//   valid_i, memOp_i     MEM instruction valid and {funct3, dmWR, workEn}
//   addr_i, wdata_i      effective byte address and store data
//   stall_o              hold the upstream pipeline while the access is open
//   done_o, err_o        one-cycle completion pulse, err_o flags a fault
//   rdata_o              extended load result, held between loads
//   dm_req/we/addr/be/wdata, dm_ack, dm_rdata   data-memory port
// Parameter TIMEOUT: ACCESS cycles allowed without dm_ack before a fault.
// Build option MEM_MISALIGN_TRAP_EN: fault misaligned half/word accesses
// instead of truncating the low address bits.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  memOp_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  memState_t          state, stateNext;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addrR, wdataR;
  logic [2:0]         f3R;
  logic               weR;
  logic               accept, reqBad, doneNext, errNext;
  logic [3:0]         beW;
  logic [31:0]        wdataRepW, rdataExtW;

  assign accept = valid_i && memOp_i[0];

  // Requests that complete with a fault straight from IDLE, never touching memory.
  always_comb begin
    reqBad = isIllegalF3(memOp_i[4:2]);
`ifdef MEM_MISALIGN_TRAP_EN
    reqBad = reqBad || isMisaligned(memOp_i[4:2], addr_i[1:0]);
`endif
  end

  always_comb begin
    stateNext = state;
    stall_o   = 1'b0;
    dm_req    = 1'b0;
    doneNext  = 1'b0;
    errNext   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          if (reqBad) begin
            stateNext = ST_RESP;
            doneNext  = 1'b1;
            errNext   = 1'b1;
          end else begin
            stateNext = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        stall_o = 1'b1;
        dm_req  = 1'b1;
        // An ack on the final allowed cycle still counts as success.
        if (dm_ack) begin
          stateNext = ST_RESP;
          doneNext  = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          stateNext = ST_RESP;
          doneNext  = 1'b1;
          errNext   = 1'b1;
        end
      end
      ST_RESP: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      state  <= stateNext;
      done_o <= doneNext;
      err_o  <= errNext;
      if (state != ST_ACCESS)
        cnt <= '0;
      else if (!dm_ack)
        cnt <= cnt + 1'b1;
      if ((state == ST_ACCESS) && dm_ack && !weR)
        rdata_o <= rdataExtW;
    end
  end

  // Request capture; only meaningful once the FSM leaves IDLE, so no reset.
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && accept) begin
      addrR  <= addr_i;
      wdataR <= wdata_i;
      f3R    <= memOp_i[4:2];
      weR    <= memOp_i[1];
    end
  end

  mem_lane_align uLane (
    .funct3   (f3R),
    .addrLo   (addrR[1:0]),
    .wdata    (wdataR),
    .rdata    (dm_rdata),
    .be       (beW),
    .wdataRep (wdataRepW),
    .rdataExt (rdataExtW)
  );

  assign dm_we    = dm_req && weR;
  assign dm_addr  = {addrR[31:2], 2'b00};
  assign dm_be    = beW;
  assign dm_wdata = wdataRepW;

endmodule
